frv_rng_core: RTL and testbench

Pseudo-random number source sitting directly downstream of the CPU RNG interface. It accepts one-hot test/seed/sample requests over a valid/ready request channel, maintains a seeded 32-bit Galois LFSR with a seed-count initialisation rule and a repetition health check, and returns status plus sample data over a valid/ready response channel. One transaction is in flight at a time.

---
 rtl/frv_rng_core_if.sv | 22 ++
 rtl/frv_rng_core.sv | 134 +++++++++++++
 tb/tb_frv_rng_core.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_rng_core_if.sv
// Request/response channel between the CPU RNG port and frv_rng_core.
// master = requester side, slave = the RNG core.
interface frv_rng_core_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_data
  );
endinterface

// File: rtl/frv_rng_core.sv
// Free-running seeded 32-bit Galois LFSR with seed-count gating and a repeated-sample
// health check; one request in flight, response held until rsp_ready.
module frv_rng_core #(
  parameter int unsigned SEED_THRESH = 2,
  parameter int unsigned MIX_CYCLES  = 4,
  parameter logic [31:0] RESET_STATE = 32'h0000_0001
) (
  input logic           g_clk,
  input logic           g_resetn,
  frv_rng_core_if.slave rng
);

  localparam logic [2:0]  ST_NO_INIT   = 3'b000;
  localparam logic [2:0]  ST_UNHEALTHY = 3'b100;
  localparam logic [2:0]  ST_HEALTHY   = 3'b101;
  localparam logic [3:0]  THRESH       = 4'(SEED_THRESH);
  localparam logic [3:0]  MIX_LOAD     = 4'(MIX_CYCLES);
  localparam logic [31:0] TAPS         = 32'h8020_0003;

  // req_op bit order is {test, samp, seed}
  localparam logic [2:0] OP_SEED = 3'b001;
  localparam logic [2:0] OP_SAMP = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MIX,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] last_samp_q, last_samp_d;
  logic [3:0]  seed_cnt_q, seed_cnt_d;
  logic [3:0]  mix_cnt_q, mix_cnt_d;
  logic        rep_fail_q, rep_fail_d;
  logic [2:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        req_rdy;
  logic        req_hs;
  logic [2:0]  cur_status;
  logic [31:0] seeded;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  assign req_rdy        = g_resetn && (state_q == S_IDLE);
  assign req_hs         = rng.req_valid && req_rdy;
  assign rng.req_ready  = req_rdy;
  assign rng.rsp_valid  = (state_q == S_RESP);
  assign rng.rsp_status = rsp_status_q;
  assign rng.rsp_data   = rsp_data_q;

  assign cur_status = (seed_cnt_q < THRESH) ? ST_NO_INIT :
                      rep_fail_q            ? ST_UNHEALTHY : ST_HEALTHY;
  assign seeded     = lfsr_step(lfsr_q ^ rng.req_data);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_step(lfsr_q);
    last_samp_d  = last_samp_q;
    seed_cnt_d   = seed_cnt_q;
    mix_cnt_d    = mix_cnt_q;
    rep_fail_d   = rep_fail_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          if (rng.req_op == OP_SEED) begin
            // An all-zero LFSR would lock up, so a cancelling seed lands on 1.
            lfsr_d     = (seeded == 32'h0) ? 32'h1 : seeded;
            seed_cnt_d = (seed_cnt_q == 4'hF) ? seed_cnt_q : seed_cnt_q + 4'd1;
            rep_fail_d = 1'b0;
            mix_cnt_d  = MIX_LOAD;
            state_d    = S_MIX;
          end else begin
            rsp_status_d = cur_status;
            rsp_data_d   = 32'h0;
            // The response carries the pre-update health; a repeat shows up on the next one.
            if (rng.req_op == OP_SAMP && cur_status == ST_HEALTHY) begin
              rsp_data_d  = lfsr_q;
              last_samp_d = lfsr_q;
              if (lfsr_q == last_samp_q) begin
                rep_fail_d = 1'b1;
              end
            end
            state_d = S_RESP;
          end
        end
      end
      S_MIX: begin
        if (mix_cnt_q == 4'd1) begin
          rsp_status_d = cur_status;
          rsp_data_d   = 32'h0;
          state_d      = S_RESP;
        end else begin
          mix_cnt_d = mix_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rng.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= S_IDLE;
      lfsr_q       <= RESET_STATE;
      last_samp_q  <= 32'h0;
      seed_cnt_q   <= 4'h0;
      mix_cnt_q    <= 4'h0;
      rep_fail_q   <= 1'b0;
      rsp_status_q <= ST_NO_INIT;
      rsp_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      last_samp_q  <= last_samp_d;
      seed_cnt_q   <= seed_cnt_d;
      mix_cnt_q    <= mix_cnt_d;
      rep_fail_q   <= rep_fail_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_frv_rng_core.sv
// Directed bench for frv_rng_core: reset, seeding, sampling, backpressure,
// zero-seed recovery and the repetition health check.
module tb_frv_rng_core;

  logic        g_clk    = 1'b0;
  logic        g_resetn = 1'b0;
  int          vec_cnt  = 0;
  int          err_cnt  = 0;
  logic [31:0] m_lfsr;
  logic        seed_pend = 1'b0;
  logic [31:0] seed_val  = 32'h0;
  logic [31:0] force_val = 32'h0;

  frv_rng_core_if rng ();

  frv_rng_core #(
    .SEED_THRESH(2),
    .MIX_CYCLES (4),
    .RESET_STATE(32'h0000_0001)
  ) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .rng     (rng)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Reference LFSR; seed_pend is raised by the bench only for a guaranteed seed acceptance
  always @(posedge g_clk) begin
    if (!g_resetn)
      m_lfsr <= 32'h1;
    else if (seed_pend)
      m_lfsr <= (step(m_lfsr ^ seed_val) == 32'h0) ? 32'h1 : step(m_lfsr ^ seed_val);
    else
      m_lfsr <= step(m_lfsr);
  end

  task automatic send(input logic [2:0] op, input logic [31:0] d, output logic [31:0] cap);
    @(negedge g_clk);
    cap = m_lfsr;
    rng.req_valid = 1'b1;
    rng.req_op    = op;
    rng.req_data  = d;
    if (op == 3'b001) begin
      seed_pend = 1'b1;
      seed_val  = d;
    end
    @(posedge g_clk);
    #1;
    rng.req_valid = 1'b0;
    rng.req_op    = 3'b000;
    rng.req_data  = 32'h0;
    seed_pend     = 1'b0;
  endtask

  // Returns 1 if rsp_valid is already up one cycle after acceptance; 0 on timeout
  task automatic wait_rsp(input int max, output int cyc);
    cyc = 1;
    while (rng.rsp_valid !== 1'b1 && cyc < max) begin
      @(posedge g_clk);
      #1;
      cyc++;
    end
    if (rng.rsp_valid !== 1'b1) cyc = 0;
  endtask

  task automatic ack();
    @(negedge g_clk);
    rng.rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
    rng.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    vec_cnt++; if (rng.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid got %b want 0", rng.rsp_valid); end
    vec_cnt++; if (rng.rsp_status !== 3'b000) begin err_cnt++; $display("FAIL reset_status got %b want 000", rng.rsp_status); end
    vec_cnt++; if (rng.rsp_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data got %h want 0", rng.rsp_data); end
    vec_cnt++; if (rng.req_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_req_ready_in_reset got %b want 0", rng.req_ready); end
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    vec_cnt++; if (rng.req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready_after got %b want 1", rng.req_ready); end
    vec_cnt++; if (dut.lfsr_q !== 32'h8020_0003) begin err_cnt++; $display("FAIL reset_first_step got %h want 80200003", dut.lfsr_q); end
  endtask

  task automatic test_samp_uninit();
    logic [31:0] cap;
    int cyc;
    send(3'b010, 32'h0, cap);
    wait_rsp(5, cyc);
    vec_cnt++; if (cyc != 1) begin err_cnt++; $display("FAIL uninit_latency got %0d want 1", cyc); end
    vec_cnt++; if (rng.rsp_status !== 3'b000) begin err_cnt++; $display("FAIL uninit_status got %b want 000", rng.rsp_status); end
    vec_cnt++; if (rng.rsp_data !== 32'h0) begin err_cnt++; $display("FAIL uninit_data got %h want 0", rng.rsp_data); end
    ack();
  endtask

  task automatic test_seed();
    logic [31:0] seeds [2];
    logic [2:0]  want  [2];
    logic [31:0] cap;
    int cyc;
    seeds[0] = 32'hDEAD_BEEF; want[0] = 3'b000;
    seeds[1] = 32'h1234_5678; want[1] = 3'b101;
    for (int i = 0; i < 2; i++) begin
      send(3'b001, seeds[i], cap);
      wait_rsp(12, cyc);
      vec_cnt++; if (cyc != 5) begin err_cnt++; $display("FAIL seed%0d_latency got %0d want 5", i, cyc); end
      vec_cnt++; if (rng.rsp_status !== want[i]) begin err_cnt++; $display("FAIL seed%0d_status got %b want %b", i, rng.rsp_status, want[i]); end
      vec_cnt++; if (rng.rsp_data !== 32'h0) begin err_cnt++; $display("FAIL seed%0d_data got %h want 0", i, rng.rsp_data); end
      vec_cnt++; if (dut.lfsr_q !== m_lfsr) begin err_cnt++; $display("FAIL seed%0d_lfsr got %h want %h", i, dut.lfsr_q, m_lfsr); end
      ack();
    end
  endtask

  task automatic test_samp_healthy();
    logic [31:0] exp1, exp2, got1;
    int cyc;
    bit stable;
    send(3'b010, 32'h0, exp1);
    wait_rsp(5, cyc);
    got1 = rng.rsp_data;
    vec_cnt++; if (cyc != 1) begin err_cnt++; $display("FAIL samp_latency got %0d want 1", cyc); end
    vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL samp_status got %b want 101", rng.rsp_status); end
    vec_cnt++; if (got1 !== exp1) begin err_cnt++; $display("FAIL samp_data got %h want %h", got1, exp1); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge g_clk);
      #1;
      if (rng.rsp_valid !== 1'b1 || rng.rsp_status !== 3'b101 || rng.rsp_data !== exp1) stable = 1'b0;
    end
    vec_cnt++; if (stable !== 1'b1) begin err_cnt++; $display("FAIL samp_hold got valid=%b data=%h want valid=1 data=%h", rng.rsp_valid, rng.rsp_data, exp1); end
    ack();
    vec_cnt++; if (rng.req_ready !== 1'b1) begin err_cnt++; $display("FAIL samp_ready_after_ack got %b want 1", rng.req_ready); end
    send(3'b010, 32'h0, exp2);
    wait_rsp(5, cyc);
    vec_cnt++; if (rng.rsp_data !== exp2) begin err_cnt++; $display("FAIL samp2_data got %h want %h", rng.rsp_data, exp2); end
    vec_cnt++; if (rng.rsp_data === got1) begin err_cnt++; $display("FAIL samp2_differs got %h want not %h", rng.rsp_data, got1); end
    vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL samp2_status got %b want 101", rng.rsp_status); end
    ack();
  endtask

  task automatic test_invalid_op();
    logic [2:0] ops [2];
    logic [31:0] cap;
    int cyc;
    ops[0] = 3'b000;
    ops[1] = 3'b011;
    for (int i = 0; i < 2; i++) begin
      send(ops[i], 32'hFFFF_0000, cap);
      wait_rsp(5, cyc);
      vec_cnt++; if (cyc != 1) begin err_cnt++; $display("FAIL inv%0d_latency got %0d want 1", i, cyc); end
      vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL inv%0d_status got %b want 101", i, rng.rsp_status); end
      vec_cnt++; if (rng.rsp_data !== 32'h0) begin err_cnt++; $display("FAIL inv%0d_data got %h want 0", i, rng.rsp_data); end
      vec_cnt++; if (dut.lfsr_q !== m_lfsr) begin err_cnt++; $display("FAIL inv%0d_no_reseed got %h want %h", i, dut.lfsr_q, m_lfsr); end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap;
    rng.rsp_ready = 1'b1;
    send(3'b100, 32'h0, cap);
    vec_cnt++; if (rng.rsp_valid !== 1'b1 || rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL b2b_test_rsp got valid=%b status=%b want 1/101", rng.rsp_valid, rng.rsp_status); end
    @(posedge g_clk);
    #1;
    vec_cnt++; if (rng.req_ready !== 1'b1 || rng.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_ready got ready=%b valid=%b want 1/0", rng.req_ready, rng.rsp_valid); end
    send(3'b010, 32'h0, cap);
    vec_cnt++; if (rng.rsp_valid !== 1'b1 || rng.rsp_data !== cap) begin err_cnt++; $display("FAIL b2b_samp got valid=%b data=%h want 1/%h", rng.rsp_valid, rng.rsp_data, cap); end
    @(posedge g_clk);
    #1;
    rng.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] cap;
    send(3'b010, 32'h0, cap);
    @(negedge g_clk);
    g_resetn = 1'b0;
    @(posedge g_clk);
    #1;
    vec_cnt++; if (rng.rsp_valid !== 1'b0 || rng.rsp_status !== 3'b000 || rng.rsp_data !== 32'h0) begin err_cnt++; $display("FAIL rst_mid got valid=%b status=%b data=%h want 0/000/0", rng.rsp_valid, rng.rsp_status, rng.rsp_data); end
    vec_cnt++; if (dut.lfsr_q !== 32'h1) begin err_cnt++; $display("FAIL rst_mid_lfsr got %h want 1", dut.lfsr_q); end
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_zero_seed();
    logic [31:0] d;
    int cyc;
    @(negedge g_clk);
    d = m_lfsr;
    rng.req_valid = 1'b1;
    rng.req_op    = 3'b001;
    rng.req_data  = d;
    seed_pend     = 1'b1;
    seed_val      = d;
    @(posedge g_clk);
    #1;
    rng.req_valid = 1'b0;
    rng.req_op    = 3'b000;
    rng.req_data  = 32'h0;
    seed_pend     = 1'b0;
    vec_cnt++; if (dut.lfsr_q !== 32'h1) begin err_cnt++; $display("FAIL zseed_lfsr got %h want 1", dut.lfsr_q); end
    wait_rsp(12, cyc);
    vec_cnt++; if (cyc != 5) begin err_cnt++; $display("FAIL zseed_latency got %0d want 5", cyc); end
    vec_cnt++; if (dut.lfsr_q === 32'h0 || dut.lfsr_q !== m_lfsr) begin err_cnt++; $display("FAIL zseed_track got %h want %h", dut.lfsr_q, m_lfsr); end
    vec_cnt++; if (rng.rsp_status !== 3'b000) begin err_cnt++; $display("FAIL zseed_status got %b want 000", rng.rsp_status); end
    ack();
  endtask

  task automatic test_repetition();
    logic [31:0] cap;
    int cyc;
    send(3'b001, 32'h0BAD_F00D, cap);
    wait_rsp(12, cyc);
    vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL rep_seed_status got %b want 101", rng.rsp_status); end
    ack();
    send(3'b010, 32'h0, cap);
    wait_rsp(5, cyc);
    force_val = rng.rsp_data;
    vec_cnt++; if (force_val !== cap) begin err_cnt++; $display("FAIL rep_first_data got %h want %h", force_val, cap); end
    ack();
    @(negedge g_clk);
    force dut.lfsr_q = force_val;
    rng.req_valid = 1'b1;
    rng.req_op    = 3'b010;
    @(posedge g_clk);
    #1;
    release dut.lfsr_q;
    rng.req_valid = 1'b0;
    rng.req_op    = 3'b000;
    wait_rsp(5, cyc);
    vec_cnt++; if (rng.rsp_status !== 3'b101 || rng.rsp_data !== force_val) begin err_cnt++; $display("FAIL rep_samp got status=%b data=%h want 101/%h", rng.rsp_status, rng.rsp_data, force_val); end
    ack();
    send(3'b100, 32'h0, cap);
    wait_rsp(5, cyc);
    vec_cnt++; if (rng.rsp_status !== 3'b100) begin err_cnt++; $display("FAIL rep_unhealthy got %b want 100", rng.rsp_status); end
    ack();
    send(3'b001, 32'h5555_AAAA, cap);
    wait_rsp(12, cyc);
    vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL rep_reseed_status got %b want 101", rng.rsp_status); end
    ack();
    send(3'b100, 32'h0, cap);
    wait_rsp(5, cyc);
    vec_cnt++; if (rng.rsp_status !== 3'b101) begin err_cnt++; $display("FAIL rep_recovered got %b want 101", rng.rsp_status); end
    ack();
  endtask

  initial begin
    rng.req_valid = 1'b0;
    rng.req_op    = 3'b000;
    rng.req_data  = 32'h0;
    rng.rsp_ready = 1'b0;
    test_reset();
    test_samp_uninit();
    test_seed();
    test_samp_healthy();
    test_invalid_op();
    test_back_to_back();
    test_reset_mid();
    test_zero_seed();
    test_repetition();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
